// File: rtl/taylor_cos_seq.sv
// Horner-scheme cos(x) sequencer driving one shared FP multiplier and adder.
// Ports: clk/rst_n, start/x in, busy/done/result out, lut_idx/lut_coef LUT,
//        mul_* and add_* start/done handshakes to the external FP units.
module taylor_cos_seq #(
    parameter int NUM_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  lut_idx,
    input  logic [31:0] lut_coef,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_done,
    input  logic [31:0] add_result
);

    localparam logic [1:0] LAST = 2'(NUM_TERMS - 1);

    typedef enum logic [3:0] {
        IDLE,
        SQ_REQ,
        SQ_WAIT,
        LOAD,
        MUL_REQ,
        MUL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic        mul_start_q, mul_start_d;
    logic        add_start_q, add_start_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    // Outputs are registered: each request/pulse is set on the edge that
    // enters the state where it must be visible.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        res_d       = res_q;
        idx_d       = idx_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        mul_start_d = 1'b0;
        add_start_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d         = x;
                    idx_d       = LAST;
                    mul_a_d     = x;
                    mul_b_d     = x;
                    mul_start_d = 1'b1;
                    state_d     = SQ_REQ;
                end
            end
            SQ_REQ: state_d = SQ_WAIT;
            SQ_WAIT: begin
                if (mul_done) begin
                    y_d     = mul_result;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d = lut_coef;
                if (idx_q == 2'd0) begin
                    res_d   = lut_coef;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d       = idx_q - 2'd1;
                    mul_a_d     = lut_coef;
                    mul_b_d     = y_q;
                    mul_start_d = 1'b1;
                    state_d     = MUL_REQ;
                end
            end
            MUL_REQ: state_d = MUL_WAIT;
            MUL_WAIT: begin
                // lut_idx already points at the coefficient to add
                if (mul_done) begin
                    acc_d       = mul_result;
                    add_a_d     = mul_result;
                    add_b_d     = lut_coef;
                    add_start_d = 1'b1;
                    state_d     = ADD_REQ;
                end
            end
            ADD_REQ: state_d = ADD_WAIT;
            ADD_WAIT: begin
                if (add_done) begin
                    acc_d = add_result;
                    if (idx_q == 2'd0) begin
                        res_d   = add_result;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_q - 2'd1;
                        mul_a_d     = add_result;
                        mul_b_d     = y_q;
                        mul_start_d = 1'b1;
                        state_d     = MUL_REQ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            mul_start_q <= 1'b0;
            add_start_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            idx_q       <= idx_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            mul_start_q <= mul_start_d;
            add_start_q <= add_start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign lut_idx   = idx_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_taylor_cos_seq.sv
// Directed bench for taylor_cos_seq with behavioural FP mul/add units.
// A second instance covers the single-term configuration.
module tb_taylor_cos_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [1:0]  lut_idx;
    logic [31:0] lut_coef;
    logic        mul_start, add_start;
    logic [31:0] mul_a, mul_b, add_a, add_b;
    logic        mul_done, add_done;
    logic [31:0] mul_result = '0;
    logic [31:0] add_result = '0;
    logic        mul_done_m = 1'b0, add_done_m = 1'b0;
    logic        spur_mul = 1'b0, spur_add = 1'b0;

    assign mul_done = mul_done_m | spur_mul;
    assign add_done = add_done_m | spur_add;

    logic        start1 = 1'b0;
    logic [31:0] x1 = '0;
    logic        busy1, done1;
    logic [31:0] result1;
    logic [1:0]  lut_idx1;
    logic [31:0] lut_coef1;
    logic        mul_start1, add_start1;
    logic [31:0] mul_a1, mul_b1, add_a1, add_b1;
    logic        mul_done1 = 1'b0;
    logic [31:0] mul_result1 = '0;
    logic        add_done1 = 1'b0;
    logic [31:0] add_result1 = '0;

    function automatic logic [31:0] lut(input logic [1:0] i);
        case (i)
            2'd0: return 32'h3F800000;
            2'd1: return 32'hBF000000;
            2'd2: return 32'h3D2AAAAB;
            default: return 32'hBAB60B61;
        endcase
    endfunction

    assign lut_coef  = lut(lut_idx);
    assign lut_coef1 = lut(lut_idx1);

    taylor_cos_seq #(.NUM_TERMS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x),
        .busy(busy), .done(done), .result(result),
        .lut_idx(lut_idx), .lut_coef(lut_coef),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_result(add_result)
    );

    taylor_cos_seq #(.NUM_TERMS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1),
        .busy(busy1), .done(done1), .result(result1),
        .lut_idx(lut_idx1), .lut_coef(lut_coef1),
        .mul_start(mul_start1), .mul_a(mul_a1), .mul_b(mul_b1),
        .mul_done(mul_done1), .mul_result(mul_result1),
        .add_start(add_start1), .add_a(add_a1), .add_b(add_b1),
        .add_done(add_done1), .add_result(add_result1)
    );

    function automatic real sp2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real v);
        real    a;
        int     e;
        longint f;
        logic   s;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        f = longint'((a - 1.0) * 8388608.0);
        if (f >= 64'sd8388608) begin f = 0; e++; end
        return {s, e[7:0], f[22:0]};
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] xv);
        logic [31:0] y, acc;
        y   = r2sp(sp2r(xv) * sp2r(xv));
        acc = lut(2'd3);
        for (int i = 2; i >= 0; i--) begin
            acc = r2sp(sp2r(acc) * sp2r(y));
            acc = r2sp(sp2r(acc) + sp2r(lut(2'(i))));
        end
        return acc;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rand_lat = 1'b0;
    bit chk_stab = 1'b1;
    int lm_fix = 1, la_fix = 1;
    int m_cnt = 0, a_cnt = 0;
    int lat_sum_m = 0, lat_sum_a = 0;
    int stab_err_m = 0, stab_err_a = 0;
    logic [31:0] m_a, m_b, a_a, a_b;
    logic [31:0] mul_log_a[$], mul_log_b[$], add_log_b[$];

    always @(negedge clk) begin
        mul_done_m = 1'b0;
        if (m_cnt > 0) begin
            if (chk_stab && (mul_a !== m_a || mul_b !== m_b)) stab_err_m++;
            m_cnt--;
            if (m_cnt == 0) begin
                mul_done_m = 1'b1;
                mul_result = r2sp(sp2r(m_a) * sp2r(m_b));
            end
        end
        if (mul_start) begin
            m_a = mul_a;
            m_b = mul_b;
            m_cnt = rand_lat ? int'($urandom_range(1, 8)) : lm_fix;
            lat_sum_m += m_cnt;
            mul_log_a.push_back(mul_a);
            mul_log_b.push_back(mul_b);
        end
    end

    always @(negedge clk) begin
        add_done_m = 1'b0;
        if (a_cnt > 0) begin
            if (chk_stab && (add_a !== a_a || add_b !== a_b)) stab_err_a++;
            a_cnt--;
            if (a_cnt == 0) begin
                add_done_m = 1'b1;
                add_result = r2sp(sp2r(a_a) + sp2r(a_b));
            end
        end
        if (add_start) begin
            a_a = add_a;
            a_b = add_b;
            a_cnt = rand_lat ? int'($urandom_range(1, 8)) : la_fix;
            lat_sum_a += a_cnt;
            add_log_b.push_back(add_b);
        end
    end

    int m1_cnt = 0;
    logic [31:0] m1_a = '0, m1_b = '0;
    always @(negedge clk) begin
        mul_done1 = 1'b0;
        if (m1_cnt > 0) begin
            m1_cnt--;
            if (m1_cnt == 0) begin
                mul_done1 = 1'b1;
                mul_result1 = r2sp(sp2r(m1_a) * sp2r(m1_b));
            end
        end
        if (mul_start1) begin
            m1_a = mul_a1;
            m1_b = mul_b1;
            m1_cnt = 3;
        end
    end

    int n_done = 0, n_mst = 0, n_ast = 0, n_busy = 0, n_ast1 = 0;
    always @(negedge clk) begin
        if (done) n_done++;
        if (mul_start) n_mst++;
        if (add_start) n_ast++;
        if (busy) n_busy++;
        if (add_start1) n_ast1++;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic do_op(input logic [31:0] xv,
                         output logic [31:0] res, output int dc);
        int t0;
        bit got;
        @(negedge clk);
        start = 1'b1;
        x = xv;
        t0 = cyc;
        dc = -1;
        res = '0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin got = 1'b1; dc = cyc - t0; res = result; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, mul_start, add_start} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, mul_start, add_start});
        end
        n_checks++;
        if (result !== 32'h0 || lut_idx !== 2'd0) begin
            n_err++;
            $display("FAIL reset_result: got %h/%0d want 0/0", result, lut_idx);
        end
        n_checks++;
        if ({mul_a, mul_b, add_a, add_b} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_operands: got %h %h %h %h want 0", mul_a, mul_b, add_a, add_b);
        end
        rst_n = 1'b1;
        spur_mul = 1'b1;
        spur_add = 1'b1;
        @(negedge clk);
        spur_mul = 1'b0;
        spur_add = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_done !== 0 || n_mst !== 0) begin
            n_err++;
            $display("FAIL reset_stray_done: busy %b dones %0d muls %0d want 0 0 0", busy, n_done, n_mst);
        end
    endtask

    task automatic test_zero();
        logic [31:0] res;
        int dc, nb0;
        nb0 = n_busy;
        do_op(32'h0, res, dc);
        @(negedge clk);
        n_checks++;
        if (dc !== 16) begin n_err++; $display("FAIL zero_latency: got %0d want 16", dc); end
        n_checks++;
        if (res !== 32'h3F800000) begin n_err++; $display("FAIL zero_result: got %h want 3f800000", res); end
        n_checks++;
        if (n_busy - nb0 !== 16) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 16", n_busy - nb0); end
        n_checks++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_one();
        logic [31:0] res;
        int dc, mb, ab, d, m0, a0;
        mb = mul_log_a.size();
        ab = add_log_b.size();
        m0 = n_mst;
        a0 = n_ast;
        do_op(32'h3F800000, res, dc);
        repeat (2) @(negedge clk);
        n_checks++;
        if (res !== golden(32'h3F800000)) begin
            n_err++; $display("FAIL one_result: got %h want %h", res, golden(32'h3F800000));
        end
        d = int'(res) - int'(32'h3F0A4FA6);
        n_checks++;
        if (d < -4 || d > 4) begin n_err++; $display("FAIL one_ulp: got %h want 3f0a4fa6 +-4", res); end
        n_checks++;
        if (n_mst - m0 !== 4 || n_ast - a0 !== 3) begin
            n_err++; $display("FAIL one_op_count: got %0d/%0d want 4/3", n_mst - m0, n_ast - a0);
        end
        n_checks++;
        if (mul_log_a[mb] !== 32'h3F800000 || mul_log_b[mb] !== 32'h3F800000) begin
            n_err++; $display("FAIL one_square_ops: got %h %h want 3f800000 x2", mul_log_a[mb], mul_log_b[mb]);
        end
        n_checks++;
        if (mul_log_a[mb+1] !== 32'hBAB60B61 || mul_log_b[mb+1] !== 32'h3F800000) begin
            n_err++; $display("FAIL one_first_mul: got %h %h want bab60b61 3f800000", mul_log_a[mb+1], mul_log_b[mb+1]);
        end
        n_checks++;
        if ({add_log_b[ab], add_log_b[ab+1], add_log_b[ab+2]} !== {32'h3D2AAAAB, 32'hBF000000, 32'h3F800000}) begin
            n_err++;
            $display("FAIL one_add_coefs: got %h %h %h want 3d2aaaab bf000000 3f800000",
                     add_log_b[ab], add_log_b[ab+1], add_log_b[ab+2]);
        end
    endtask

    task automatic test_random_lat();
        logic [31:0] xs[3] = '{32'h3F800000, 32'h3FC00000, 32'hBF400000};
        logic [31:0] res;
        int dc, sm0, sa0, se0, exp_dc;
        rand_lat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sm0 = lat_sum_m;
            sa0 = lat_sum_a;
            se0 = stab_err_m + stab_err_a;
            do_op(xs[k], res, dc);
            exp_dc = 3 + (lat_sum_m - sm0) + (lat_sum_a - sa0) + 6;
            @(negedge clk);
            n_checks++;
            if (res !== golden(xs[k])) begin
                n_err++; $display("FAIL rand_result[%0d]: got %h want %h", k, res, golden(xs[k]));
            end
            n_checks++;
            if (dc !== exp_dc) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, dc, exp_dc); end
            n_checks++;
            if (stab_err_m + stab_err_a - se0 !== 0) begin
                n_err++; $display("FAIL rand_stable[%0d]: got %0d changes want 0", k, stab_err_m + stab_err_a - se0);
            end
        end
        rand_lat = 1'b0;
    endtask

    task automatic test_hold_spurious();
        logic [31:0] res;
        int t0, k, dc, nd0, m0, a0;
        bit got;
        @(negedge clk);
        spur_mul = 1'b1;
        spur_add = 1'b1;
        @(negedge clk);
        spur_mul = 1'b0;
        spur_add = 1'b0;
        nd0 = n_done;
        m0 = n_mst;
        a0 = n_ast;
        start = 1'b1;
        x = 32'h3F800000;
        t0 = cyc;
        got = 1'b0;
        dc = -1;
        res = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            k = cyc - t0;
            spur_mul = (k == 1 || k == 4 || k == 6);
            spur_add = (k == 1 || k == 4 || k == 6);
            if (done) begin got = 1'b1; dc = k; res = result; end
        end
        start = 1'b0;
        spur_mul = 1'b0;
        spur_add = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_done - nd0 !== 1) begin n_err++; $display("FAIL hold_done_count: got %0d want 1", n_done - nd0); end
        n_checks++;
        if (res !== golden(32'h3F800000) || dc !== 16) begin
            n_err++; $display("FAIL hold_result: got %h@%0d want %h@16", res, dc, golden(32'h3F800000));
        end
        n_checks++;
        if (n_mst - m0 !== 4 || n_ast - a0 !== 3) begin
            n_err++; $display("FAIL hold_op_count: got %0d/%0d want 4/3", n_mst - m0, n_ast - a0);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int t0, dc, nd0, bad;
        @(negedge clk);
        lm_fix = 5;
        chk_stab = 1'b0;
        start = 1'b1;
        x = 32'h3F800000;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mul_start, add_start, lut_idx} !== 6'b0 || result !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_state: got %b %h want 0", {busy, done, mul_start, add_start, lut_idx}, result);
        end
        n_checks++;
        if ({mul_a, mul_b, add_a, add_b} !== 128'h0) begin
            n_err++; $display("FAIL midrst_operands: got %h %h %h %h want 0", mul_a, mul_b, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd0 = n_done;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done || mul_start || add_start) bad++;
        end
        n_checks++;
        if (bad !== 0 || n_done - nd0 !== 0) begin
            n_err++; $display("FAIL midrst_late_done: got %0d active cycles %0d dones want 0 0", bad, n_done - nd0);
        end
        lm_fix = 1;
        chk_stab = 1'b1;
        do_op(32'h0, res, dc);
        n_checks++;
        if (res !== 32'h3F800000 || dc !== 16) begin
            n_err++; $display("FAIL midrst_recover: got %h@%0d want 3f800000@16", res, dc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int t0, t1, d1, d2, phase;
        @(negedge clk);
        start = 1'b1;
        x = 32'h0;
        t0 = cyc;
        t1 = 0;
        d1 = -1;
        d2 = -1;
        r1 = '0;
        r2 = '0;
        phase = 0;
        for (int i = 0; i < 100 && phase < 2; i++) begin
            @(negedge clk);
            if (phase == 0) begin
                start = 1'b0;
                if (done) begin
                    d1 = cyc - t0;
                    r1 = result;
                    start = 1'b1;
                    x = 32'h3F800000;
                    t1 = cyc + 1;
                    phase = 1;
                end
            end else begin
                if (cyc - t1 >= 1) start = 1'b0;
                if (done) begin d2 = cyc - t1; r2 = result; phase = 2; end
            end
        end
        start = 1'b0;
        n_checks++;
        if (r1 !== 32'h3F800000 || d1 !== 16) begin
            n_err++; $display("FAIL b2b_first: got %h@%0d want 3f800000@16", r1, d1);
        end
        n_checks++;
        if (r2 !== golden(32'h3F800000) || d2 !== 16) begin
            n_err++; $display("FAIL b2b_second: got %h@%0d want %h@16", r2, d2, golden(32'h3F800000));
        end
    endtask

    task automatic test_single_term();
        logic [31:0] res;
        int t0, dc;
        bit got;
        @(negedge clk);
        start1 = 1'b1;
        x1 = 32'h40490FDB;
        t0 = cyc;
        got = 1'b0;
        dc = -1;
        res = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin got = 1'b1; dc = cyc - t0; res = result1; end
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dc !== 6) begin n_err++; $display("FAIL single_latency: got %0d want 6", dc); end
        n_checks++;
        if (res !== 32'h3F800000) begin n_err++; $display("FAIL single_result: got %h want 3f800000", res); end
        n_checks++;
        if (n_ast1 !== 0) begin n_err++; $display("FAIL single_no_add: got %0d add starts want 0", n_ast1); end
        n_checks++;
        if (m1_a !== 32'h40490FDB || m1_b !== 32'h40490FDB) begin
            n_err++; $display("FAIL single_square_ops: got %h %h want 40490fdb x2", m1_a, m1_b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero();
        test_one();
        test_random_lat();
        test_hold_spurious();
        test_reset_midop();
        test_back_to_back();
        test_single_term();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/taylor_cos_seq.md
Name: taylor_cos_seq

Overview:
- Sequencer that evaluates cos(x) ≈ c0 + y·(c1 + y·(c2 + y·c3)), with y = x², in IEEE-754 single precision using Horner's scheme.
- Coefficients come from the 4-entry signed inverse-factorial coefficient LUT (index 0..3 = +1, −1/2!, +1/4!, −1/6!).
- Arithmetic is done by one shared external FP multiplier and one shared external FP adder, each with a start/done handshake.
- Sits between the Taylor top level and the FP units.

Parameters:
- NUM_TERMS, 4, number of series terms used (legal 1..4); highest LUT index read is NUM_TERMS−1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- x  in  32  operand; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  cos(x) value; held until the next accepted start.
- lut_idx  out  2  registered coefficient LUT index.
- lut_coef  in  32  combinational LUT output for lut_idx.
- mul_start  out  1  one-cycle multiply request.
- mul_a, mul_b  out  32 each  multiplier operands; stable from mul_start until mul_done.
- mul_done  in  1  multiplier result valid (one cycle).
- mul_result  in  32  product.
- add_start  out  1  one-cycle add request.
- add_a, add_b  out  32 each  adder operands; stable from add_start until add_done.
- add_done  in  1  adder result valid.
- add_result  in  32  sum.

Behaviour:
- Reset (async assert, rst_n low):
  - state = IDLE.
  - busy, done, mul_start, add_start = 0.
  - result, mul_a, mul_b, add_a, add_b, internal x/y/acc = 0.
  - lut_idx = 0.
- States: IDLE, SQ_REQ, SQ_WAIT, LOAD, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, DONE.
- IDLE:
  - On start=1, capture x, set lut_idx = NUM_TERMS−1, go to SQ_REQ.
  - start while busy is ignored; no queueing.
- SQ_REQ: mul_start=1, mul_a = mul_b = x → SQ_WAIT.
- SQ_WAIT: on mul_done, latch y = mul_result → LOAD.
- LOAD:
  - acc = lut_coef (index NUM_TERMS−1).
  - If lut_idx == 0 → DONE; else lut_idx decrements → MUL_REQ.
- MUL_REQ: mul_start=1, mul_a = acc, mul_b = y → MUL_WAIT.
- MUL_WAIT: on mul_done, acc = mul_result → ADD_REQ.
- ADD_REQ: add_start=1, add_a = acc, add_b = lut_coef (current lut_idx) → ADD_WAIT.
- ADD_WAIT:
  - On add_done, acc = add_result.
  - If lut_idx == 0 → DONE; else lut_idx decrements → MUL_REQ.
- DONE: result = acc, done=1 for exactly this cycle → IDLE. busy falls the cycle after.
- Handshake rules:
  - Start pulses are exactly one cycle.
  - mul_done/add_done are honoured only in the matching WAIT state; they are ignored elsewhere, including stray or late dones after reset.
  - Done in the same cycle as the start is not legal; units have latency ≥1.
- Latency: a unit with latency L asserts done L cycles after its start cycle. With start accepted in cycle 0, done asserts in cycle 3 + Lm + (NUM_TERMS−1)·(2 + Lm + La).
  - Lm = La = 1, NUM_TERMS=4 → cycle 16.
  - NUM_TERMS=1 → cycle 3+Lm; result = c0 = 0x3F800000 regardless of x.
- Back-to-back: start may be accepted in the cycle after DONE (the first IDLE cycle).
- Reset mid-operation: immediate return to IDLE with reset values. Outstanding FP ops are not aborted; their done is ignored.
- No rounding or exception handling in this block. NaN/Inf propagate through the FP units untouched.

Test Plan:
- x=0x00000000, Lm=La=1, NUM_TERMS=4 → done in cycle 16, result 0x3F800000; busy high cycles 1–16.
- x=0x3F800000 (1.0), behavioural FP units → result 0x3F0A4FA6 ±4 ULP. The mul/add operand sequence is y=1.0; acc=0xBAB60B61; add coefs 0x3D2AAAAB, 0xBF000000, 0x3F800000, in that order.
- Random latencies Lm, La ∈ 1..8 per op with operands checked stable throughout each WAIT → result identical to the fixed-latency run; done cycle matches the formula.
- start held high through a whole operation plus spurious mul_done/add_done in IDLE/REQ states → exactly one operation per accepted start; spurious dones have no effect.
- rst_n low during MUL_WAIT, late mul_done arrives after release → all outputs at reset values, FSM stays IDLE, no done; the next start completes normally.
- NUM_TERMS=1, x=0x40490FDB → done in cycle 3+Lm, result 0x3F800000, add_start never asserted.
